// File: rtl/mux_tdm4.sv
// mux_tdm4: four-lane time-division multiplexer.
//
// Each input lane pushes into its own small FIFO. A free-running 2-bit slot
// counter visits lanes 0,1,2,3 in a fixed rotation; on every cclk edge the
// lane owning the slot pops one word onto data_out. If that lane has nothing
// buffered, the slot is still emitted, with valid=0. Empty slots are never
// skipped, so the downstream demux can recover lane position from sync.
//
// Optional feature macro: MUX_TDM4_OVERFLOW_ERR_EN
//   defined   -> err[n] is a sticky flag, set by a push attempt while lane n is full
//   undefined -> err is tied to 0 and no flag registers exist
//
// Ports:
//   cclk                 clock, rising edge
//   reset                synchronous, active-high reset
//   valid_in0..3         push request, per lane
//   data_in0..3          push data, per lane
//   full0..3             lane FIFO holds FIFO_DEPTH entries; a push is refused
//   valid                data_out carries a real word
//   data_out             serialised data, 0 when valid=0
//   sync                 marks the output cycle that belongs to lane 0's slot
//   err[3:0]             sticky per-lane overflow flags (macro only)
//
// Slot counter (the only sequencing state):
//   slot | meaning
//   0    | next edge serves lane 0 and raises sync
//   1    | next edge serves lane 1
//   2    | next edge serves lane 2
//   3    | next edge serves lane 3
module mux_tdm4 #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              valid_in3,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  output logic              full0,
  output logic              full1,
  output logic              full2,
  output logic              full3,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              sync,
  output logic [3:0]        err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [4][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [4];
  logic [PTR_W-1:0]  rd_ptr [4];
  logic [CNT_W-1:0]  cnt    [4];
  logic [1:0]        slot;

  logic [3:0]        lane_valid;
  logic [3:0]        lane_full;
  logic [3:0]        push;
  logic [3:0]        pop;
  logic [DATA_W-1:0] lane_data [4];

  assign lane_valid   = {valid_in3, valid_in2, valid_in1, valid_in0};
  assign lane_data[0] = data_in0;
  assign lane_data[1] = data_in1;
  assign lane_data[2] = data_in2;
  assign lane_data[3] = data_in3;

  // full comes straight from the registered count: a pop in the same cycle
  // does not make room for a push (no look-ahead).
  always_comb begin
    lane_full = '0;
    push      = '0;
    pop       = '0;
    for (int n = 0; n < 4; n++) begin
      lane_full[n] = (cnt[n] == CNT_W'(FIFO_DEPTH));
      push[n]      = lane_valid[n] && !lane_full[n];
      pop[n]       = (slot == 2'(n)) && (cnt[n] != '0);
    end
  end

  assign full0 = lane_full[0];
  assign full1 = lane_full[1];
  assign full2 = lane_full[2];
  assign full3 = lane_full[3];

  // Storage needs no reset; the pointers and counts define what is valid.
  always_ff @(posedge cclk) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) mem[n][wr_ptr[n]] <= lane_data[n];
    end
  end

  always_ff @(posedge cclk) begin
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        cnt[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
        case ({push[n], pop[n]})
          2'b10:   cnt[n] <= cnt[n] + CNT_W'(1);
          2'b01:   cnt[n] <= cnt[n] - CNT_W'(1);
          default: cnt[n] <= cnt[n];
        endcase
      end
    end
  end

  // The head read uses the pre-edge pointer, so a word pushed into an empty
  // FIFO on this edge is only visible to the next slot visit.
  always_ff @(posedge cclk) begin
    if (reset) begin
      slot     <= 2'd0;
      valid    <= 1'b0;
      data_out <= '0;
      sync     <= 1'b0;
    end else begin
      slot     <= slot + 2'd1;
      valid    <= pop[slot];
      data_out <= pop[slot] ? mem[slot][rd_ptr[slot]] : '0;
      sync     <= (slot == 2'd0);
    end
  end

`ifdef MUX_TDM4_OVERFLOW_ERR_EN
  logic [3:0] err_q;

  always_ff @(posedge cclk) begin
    if (reset) err_q <= '0;
    else       err_q <= err_q | (lane_valid & lane_full);
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule
